uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
Frame scheduler and arbiter that shares the single UART transmit byte path between three message sources: the 80-bit status report, the OK code and the FAIL code. It grants one source at a time using fixed priority, and latches that source's payload. It then sequences a framed byte stream (header, payload, checksum) into the UART transmitter over a valid/ready handshake. It sits between the protocol/status logic and the UART TX serializer.

Parameters:
HDR_RPT, 8'hA5, header byte for report frames
HDR_OK, 8'h4B, header byte for OK frames
HDR_FAIL, 8'hEE, header byte for FAIL frames
GAP_CYCLES, 16, idle clocks enforced between frames (0 = back-to-back)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
RPT_REQ  in  1  report request, level; held until RPT_ACK
RPT_DATA  in  80  report payload, sampled at grant
RPT_ACK  out  1  one-cycle pulse, report granted and payload latched
OK_REQ  in  1  OK request, level
OK_CODE  in  8  OK payload byte
OK_ACK  out  1  one-cycle grant pulse
FAIL_REQ  in  1  FAIL request, level
FAIL_CODE  in  8  FAIL payload byte
FAIL_ACK  out  1  one-cycle grant pulse
TX_DATA  out  8  byte to UART TX
TX_VALID  out  1  TX_DATA valid
TX_READY  in  1  UART TX accepts byte
BUSY  out  1  high in any state other than IDLE
FRAME_DONE  out  1  one-cycle pulse when checksum byte is accepted

Behaviour:
- Reset (RST_N low, async): state IDLE. All outputs 0. Shift register, byte counter, checksum and gap counter cleared. A frame in progress is abandoned and no further bytes are emitted. Requests are re-arbitrated after release.
- States: IDLE, HDR, PAYLOAD, CSUM, GAP.
- Arbitration:
  - In IDLE, any REQ high at a rising edge grants the highest-priority source: FAIL > OK > RPT.
  - At that edge: latch payload (80 bits or 8 bits), set length (10 or 1 bytes), pulse the matching ACK in the next cycle, load TX_DATA with the header, set TX_VALID=1, go to HDR.
  - Latency: REQ high to header valid = 1 cycle.
- Handshake:
  - A byte transfers at an edge where TX_VALID && TX_READY.
  - While TX_VALID=1 and TX_READY=0, TX_DATA and the state are held stable.
  - TX_VALID never drops without a transfer, except on reset.
- HDR: on transfer, go to PAYLOAD with TX_DATA = first payload byte.
- PAYLOAD:
  - Bytes are sent MSB first. Report order is RPT_DATA[79:72] down to [7:0].
  - The counter decrements per transfer. On the last payload transfer, go to CSUM with TX_DATA = checksum.
  - TX_VALID stays high across bytes, so one byte per cycle is possible when TX_READY is held high.
- Checksum:
  - 8-bit XOR of the header and all payload bytes.
  - Accumulated from the latched payload; later input changes have no effect.
- CSUM:
  - On transfer, pulse FRAME_DONE, drop TX_VALID, then go to GAP.
  - If GAP_CYCLES=0, go straight to IDLE.
- GAP: counts GAP_CYCLES clocks with TX_VALID=0, then goes to IDLE. Requests arriving during GAP wait.
- A REQ asserted during a frame stays pending; it is not lost as long as the requester holds it.
- Simultaneous REQs: one grant per frame. A lower-priority source can starve while higher-priority requests persist. This is accepted.
- A REQ deasserted before grant is simply not served. ACK is never issued without a prior grant edge.
- Frame length: report frame = 12 bytes; OK or FAIL frame = 3 bytes.

Decomposition:
- Shared package uart_pro_pkg holds:
  - header constants (HDR_RPT, HDR_OK, HDR_FAIL)
  - state enum (IDLE, HDR, PAYLOAD, CSUM, GAP)
  - source-select type (SRC_RPT, SRC_OK, SRC_FAIL)
  - payload length constants (RPT_LEN=10, CODE_LEN=1)
- One sub-module, uart_pri_arb: a combinational fixed-priority encoder that produces a one-hot grant from the three REQs, qualified by IDLE. The sequencing, shift register and checksum stay in uart_tx_sched.

Test Plan:
- Report frame:
  - Stimulus: RPT_DATA=80'h0102030405060708090A, TX_READY tied 1.
  - Required response: TX bytes A5,01,02,03,04,05,06,07,08,09,0A,AE on consecutive cycles; RPT_ACK one pulse; FRAME_DONE on the AE transfer.
- OK frame:
  - Stimulus: OK_CODE=8'h00.
  - Required response: bytes 4B,00,4B; BUSY high through the frame and GAP (16 cycles), then low.
- Simultaneous requests:
  - Stimulus: FAIL_REQ (code 8'h13) and RPT_REQ asserted in the same cycle.
  - Required response: FAIL frame EE,13,FD sent first. The report frame header follows exactly 16 idle cycles after FAIL's FRAME_DONE.
- Backpressure:
  - Stimulus: TX_READY=0 for 5 cycles while payload byte 03 is presented.
  - Required response: TX_DATA=03 and TX_VALID=1 held all 5 cycles; no duplicate or skipped byte; checksum still AE.
- Reset mid-frame:
  - Stimulus: RST_N low after the 4th report byte.
  - Required response: TX_VALID, BUSY and all ACKs go to 0 immediately. After release, with RPT_REQ still high, a fresh full 12-byte frame starts with A5.
- Late request:
  - Stimulus: with GAP_CYCLES=0, OK_REQ is raised during a report frame.
  - Required response: the OK header 4B is valid in the cycle after the report's FRAME_DONE.

Source files
------------

// File: rtl/uart_pro_pkg.sv
// Shared constants and types for the UART transmit frame scheduler.
// Headers, payload lengths, FSM states and source selectors live here.
package uart_pro_pkg;

    localparam logic [7:0] HDR_RPT  = 8'hA5;
    localparam logic [7:0] HDR_OK   = 8'h4B;
    localparam logic [7:0] HDR_FAIL = 8'hEE;

    localparam logic [3:0] RPT_LEN  = 4'd10;
    localparam logic [3:0] CODE_LEN = 4'd1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CSUM,
        GAP
    } state_e;

    // Bit positions in the one-hot grant / ack vectors
    typedef enum logic [1:0] {
        SRC_RPT  = 2'd0,
        SRC_OK   = 2'd1,
        SRC_FAIL = 2'd2
    } src_e;

endpackage

// File: rtl/uart_pri_arb.sv
// Fixed-priority grant (FAIL > OK > RPT), only while the scheduler is idle.
module uart_pri_arb
    import uart_pro_pkg::*;
(
    input  logic       idle,
    input  logic       rpt_req,
    input  logic       ok_req,
    input  logic       fail_req,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = '0;
        if (idle) begin
            if (fail_req)     gnt[SRC_FAIL] = 1'b1;
            else if (ok_req)  gnt[SRC_OK]   = 1'b1;
            else if (rpt_req) gnt[SRC_RPT]  = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates three message sources onto one UART TX byte stream and frames
// each message as header, payload (MSB first), XOR checksum, then idle gap.
module uart_tx_sched
    import uart_pro_pkg::*;
#(
    parameter int GAP_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RPT_REQ,
    input  logic [79:0] RPT_DATA,
    output logic        RPT_ACK,
    input  logic        OK_REQ,
    input  logic [7:0]  OK_CODE,
    output logic        OK_ACK,
    input  logic        FAIL_REQ,
    input  logic [7:0]  FAIL_CODE,
    output logic        FAIL_ACK,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        BUSY,
    output logic        FRAME_DONE
);

    state_e      state_q, state_d;
    logic [79:0] sh_q, sh_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  txd_q, txd_d;
    logic        txv_q, txv_d;
    logic [2:0]  ack_q, ack_d;
    logic        done_q, done_d;
    logic [2:0]  gnt;
    logic        xfer;

    uart_pri_arb u_arb (
        .idle     (state_q == IDLE),
        .rpt_req  (RPT_REQ),
        .ok_req   (OK_REQ),
        .fail_req (FAIL_REQ),
        .gnt      (gnt)
    );

    assign xfer = txv_q && TX_READY;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        gap_d   = gap_q;
        txd_d   = txd_q;
        txv_d   = txv_q;
        ack_d   = '0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d = HDR;
                    txv_d   = 1'b1;
                    ack_d   = gnt;
                    // Single-byte codes sit in the top byte so one shift path serves all sources
                    if (gnt[SRC_FAIL]) begin
                        sh_d  = {FAIL_CODE, 72'h0};
                        cnt_d = CODE_LEN;
                        txd_d = HDR_FAIL;
                    end else if (gnt[SRC_OK]) begin
                        sh_d  = {OK_CODE, 72'h0};
                        cnt_d = CODE_LEN;
                        txd_d = HDR_OK;
                    end else begin
                        sh_d  = RPT_DATA;
                        cnt_d = RPT_LEN;
                        txd_d = HDR_RPT;
                    end
                    csum_d = txd_d;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_d = PAYLOAD;
                    txd_d   = sh_q[79:72];
                    sh_d    = {sh_q[71:0], 8'h00};
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    csum_d = csum_q ^ txd_q;
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = CSUM;
                        txd_d   = csum_q ^ txd_q;
                    end else begin
                        txd_d = sh_q[79:72];
                        sh_d  = {sh_q[71:0], 8'h00};
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    txv_d  = 1'b0;
                    txd_d  = 8'h00;
                    done_d = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = 16'(GAP_CYCLES - 1);
                    end
                end
            end
            GAP: begin
                if (gap_q == 16'd0) state_d = IDLE;
                else                gap_d   = gap_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            gap_q   <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            ack_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            gap_q   <= gap_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign TX_DATA    = txd_q;
    assign TX_VALID   = txv_q;
    assign BUSY       = (state_q != IDLE);
    assign RPT_ACK    = ack_q[SRC_RPT];
    assign OK_ACK     = ack_q[SRC_OK];
    assign FAIL_ACK   = ack_q[SRC_FAIL];
    assign FRAME_DONE = done_q;

endmodule
